// File: rtl/lcd_bus_rx.sv
// rtl/lcd_bus_rx.sv - 8080-style LCD write-bus receiver producing tagged RGB565 pixel writes
//
// Purpose:
//   Synchronises the raw LCD write bus into the i_clk domain. It decodes CASET (0x2A),
//   PASET (0x2B), RAMWR (0x2C) and RAMWRC (0x3C). During a RAM write it emits one
//   x/y-tagged pixel per data strobe.
//
// Ports:
//   i_clk, i_rst_n           system clock, asynchronous active-low reset
//   i_lcd_wr/rs/cs_n/rst_n   raw bus control (asynchronous to i_clk)
//   i_lcd_data[15:0]         raw bus data
//   o_pix_valid              one-cycle pixel write pulse
//   o_pix_x/o_pix_y          pixel coordinates
//   o_pix_data[15:0]         RGB565 pixel
//   o_frame_start            one-cycle pulse on an accepted RAMWR command
//
// Optional feature (macro LCD_BUS_RX_STATS_EN):
//   o_stat_pix_cnt[31:0]     pixel writes since reset (wrapping)
//   o_stat_unk_cmd[7:0]      last unsupported command byte

module lcd_bus_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int H_RES       = 480,
  parameter int V_RES       = 854,
  parameter int X_W         = 10,
  parameter int Y_W         = 10
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_lcd_wr,
  input  logic           i_lcd_rs,
  input  logic           i_lcd_cs_n,
  input  logic           i_lcd_rst_n,
  input  logic [15:0]    i_lcd_data,
  output logic           o_pix_valid,
  output logic [X_W-1:0] o_pix_x,
  output logic [Y_W-1:0] o_pix_y,
  output logic [15:0]    o_pix_data,
`ifdef LCD_BUS_RX_STATS_EN
  output logic [31:0]    o_stat_pix_cnt,
  output logic [7:0]     o_stat_unk_cmd,
`endif
  output logic           o_frame_start
);

  localparam logic [15:0] X_LIM = 16'(H_RES - 1);
  localparam logic [15:0] Y_LIM = 16'(V_RES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CASET,
    S_PASET,
    S_RAMWR,
    S_DISCARD
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers. Data goes through the same number of stages as wr so
  // that it is still aligned with the synchronised strobe. Reset values make the
  // bus look idle: wr high and cs_n high, so releasing reset cannot fake an edge.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] wr_sr, rs_sr, cs_sr, rst_sr;
  logic [15:0]            data_sr [SYNC_STAGES];
  logic                   wr_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_sr   <= '1;
      rs_sr   <= '0;
      cs_sr   <= '1;
      rst_sr  <= '1;
      wr_prev <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) data_sr[i] <= '0;
    end else begin
      wr_sr   <= {wr_sr[SYNC_STAGES-2:0], i_lcd_wr};
      rs_sr   <= {rs_sr[SYNC_STAGES-2:0], i_lcd_rs};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], i_lcd_cs_n};
      rst_sr  <= {rst_sr[SYNC_STAGES-2:0], i_lcd_rst_n};
      wr_prev <= wr_sr[SYNC_STAGES-1];
      data_sr[0] <= i_lcd_data;
      for (int i = 1; i < SYNC_STAGES; i++) data_sr[i] <= data_sr[i-1];
    end
  end

  logic        wr_s, rs_s, cs_n_s, lcd_rst_s;
  logic [15:0] data_s;
  logic        strobe;

  assign wr_s      = wr_sr[SYNC_STAGES-1];
  assign rs_s      = rs_sr[SYNC_STAGES-1];
  assign cs_n_s    = cs_sr[SYNC_STAGES-1];
  assign lcd_rst_s = ~rst_sr[SYNC_STAGES-1];
  assign data_s    = data_sr[SYNC_STAGES-1];
  assign strobe    = wr_s & ~wr_prev & ~cs_n_s;

  // ---------------------------------------------------------------------------
  // Decoder state, window and cursor
  // ---------------------------------------------------------------------------
  state_t         state;
  logic [1:0]     param_idx;
  logic [15:0]    p_start;
  logic [7:0]     p_end_hi;
  logic [X_W-1:0] win_sc, win_ec, cur_x;
  logic [Y_W-1:0] win_sp, win_ep, cur_y;

  // Clamped window candidates, valid when the 4th parameter byte is on the bus.
  logic [15:0] end_raw;
  logic [15:0] cx_s, cx_e, cy_s, cy_e;
  logic        cmd_known;
  logic        pix_strobe;
  logic        unk_strobe;

  always_comb begin
    end_raw = {p_end_hi, data_s[7:0]};
    cx_s    = (p_start > X_LIM) ? X_LIM : p_start;
    cx_e    = (end_raw > X_LIM) ? X_LIM : end_raw;
    if (cx_s > cx_e) cx_e = cx_s;
    cy_s    = (p_start > Y_LIM) ? Y_LIM : p_start;
    cy_e    = (end_raw > Y_LIM) ? Y_LIM : end_raw;
    if (cy_s > cy_e) cy_e = cy_s;
    cmd_known = (data_s[7:0] == 8'h2A) || (data_s[7:0] == 8'h2B) ||
                (data_s[7:0] == 8'h2C) || (data_s[7:0] == 8'h3C);
    pix_strobe = strobe & rs_s & (state == S_RAMWR);
    unk_strobe = strobe & ~rs_s & ~cmd_known;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      param_idx     <= '0;
      p_start       <= '0;
      p_end_hi      <= '0;
      win_sc        <= '0;
      win_ec        <= X_W'(H_RES - 1);
      win_sp        <= '0;
      win_ep        <= Y_W'(V_RES - 1);
      cur_x         <= '0;
      cur_y         <= '0;
      o_pix_valid   <= 1'b0;
      o_pix_x       <= '0;
      o_pix_y       <= '0;
      o_pix_data    <= '0;
      o_frame_start <= 1'b0;
    end else if (lcd_rst_s) begin
      // Panel reset: same state as the system reset, held while asserted, and
      // it wins over any strobe arriving in the same cycle.
      state         <= S_IDLE;
      param_idx     <= '0;
      p_start       <= '0;
      p_end_hi      <= '0;
      win_sc        <= '0;
      win_ec        <= X_W'(H_RES - 1);
      win_sp        <= '0;
      win_ep        <= Y_W'(V_RES - 1);
      cur_x         <= '0;
      cur_y         <= '0;
      o_pix_valid   <= 1'b0;
      o_pix_x       <= '0;
      o_pix_y       <= '0;
      o_pix_data    <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_pix_valid   <= 1'b0;
      o_frame_start <= 1'b0;
      if (strobe) begin
        if (!rs_s) begin
          // A command always restarts decoding, abandoning partial parameters.
          param_idx <= '0;
          case (data_s[7:0])
            8'h2A: state <= S_CASET;
            8'h2B: state <= S_PASET;
            8'h2C: begin
              state         <= S_RAMWR;
              cur_x         <= win_sc;
              cur_y         <= win_sp;
              o_frame_start <= 1'b1;
            end
            8'h3C: state <= S_RAMWR;
            default: state <= S_DISCARD;
          endcase
        end else begin
          case (state)
            S_CASET, S_PASET: begin
              param_idx <= param_idx + 2'd1;
              case (param_idx)
                2'd0: p_start[15:8] <= data_s[7:0];
                2'd1: p_start[7:0]  <= data_s[7:0];
                2'd2: p_end_hi      <= data_s[7:0];
                default: begin
                  if (state == S_CASET) begin
                    win_sc <= X_W'(cx_s);
                    win_ec <= X_W'(cx_e);
                  end else begin
                    win_sp <= Y_W'(cy_s);
                    win_ep <= Y_W'(cy_e);
                  end
                  state <= S_IDLE;
                end
              endcase
            end
            S_RAMWR: begin
              o_pix_valid <= 1'b1;
              o_pix_x     <= cur_x;
              o_pix_y     <= cur_y;
              o_pix_data  <= data_s;
              // >= rather than == so a cursor left outside a newer window
              // (RAMWRC after CASET) still wraps instead of running away.
              if (cur_x >= win_ec) begin
                cur_x <= win_sc;
                if (cur_y >= win_ep) cur_y <= win_sp;
                else                 cur_y <= cur_y + Y_W'(1);
              end else begin
                cur_x <= cur_x + X_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef LCD_BUS_RX_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stat_pix_cnt <= '0;
      o_stat_unk_cmd <= '0;
    end else if (lcd_rst_s) begin
      o_stat_pix_cnt <= '0;
      o_stat_unk_cmd <= '0;
    end else begin
      if (pix_strobe) o_stat_pix_cnt <= o_stat_pix_cnt + 32'd1;
      if (unk_strobe) o_stat_unk_cmd <= data_s[7:0];
    end
  end
`else
  logic unused_stats;
  assign unused_stats = pix_strobe ^ unk_strobe;
`endif

endmodule
